freq_link_sched: RTL and testbench
==================================

FREQ_LINK_SCHED -- requirements
Module: freq_link_sched

Interface
REQ-001 Parameter TICK_DIV, default 24'd10_000_000, clk cycles per slot tick (legal range 2..2^24-1).
REQ-002 Parameter TX_TICKS, default 8'd8, ticks per transmit slot (legal range 1..255).
REQ-003 Parameter RX_TICKS, default 8'd8, ticks per receive slot (legal range 1..255).
REQ-004 Port clk, input, 1, sole clock; all logic rising-edge.
REQ-005 Port reset, input, 1, synchronous active-high reset.
REQ-006 Port tx_valid / tx_data, input, 1 / 8, requester byte offer; tx_data held stable while tx_valid is high and the byte is not yet accepted.
REQ-007 Port tx_ready, output, 1, accept strobe; a transfer occurs when tx_valid and tx_ready are both high.
REQ-008 Port enc_data / enc_enable, output, 8 / 1, byte and enable driven to the frequency encoder.
REQ-009 Port dec_data / dec_enable, input 8 / output 1, decoder result and decoder enable.
REQ-010 Port rx_valid / rx_data, output, 1 / 8, one-cycle strobe plus captured received byte.
REQ-011 Port slot_state, output, 2, current FSM state encoding; busy, output, 1, high when state is not IDLE.

Function
REQ-012 Tick generator: 24-bit counter counts 0..TICK_DIV-1 and wraps. tick is high for the single cycle in which the count equals TICK_DIV-1.
REQ-013 FSM states and encodings: IDLE=0, TX=1, GUARD=2, RX=3.
REQ-014 tx_ready is combinational and equals (state==IDLE && tick); it is low in every other cycle.
REQ-015 IDLE, tick, tx_valid=1: latch tx_data into enc_data, clear the slot counter, and go to TX on the next cycle.
REQ-016 IDLE, tick, tx_valid=0: clear the slot counter and go to RX. The idle slot is used for listening.
REQ-017 TX: enc_enable=1 (registered, aligned with state). Each tick increments the slot counter. The tick on which the count reaches TX_TICKS-1 moves the FSM to GUARD.
REQ-018 GUARD: both enables are 0. It lasts exactly one tick, then the FSM goes to RX with the slot counter cleared. This guarantees every TX slot is followed by an RX slot, so RX cannot be starved.
REQ-019 RX: dec_enable=1. The slot counter counts ticks as in TX. On the tick that ends the slot (count = RX_TICKS-1):
  - dec_data is captured into rx_data;
  - rx_valid pulses high for exactly one cycle, the cycle after that tick;
  - the FSM returns to IDLE.
REQ-020 enc_enable and dec_enable are never high in the same cycle.
REQ-021 enc_data holds its latched value until the next accepted byte. tx_data changes outside an acceptance are ignored.
REQ-022 rx_data holds its value until the next capture.
REQ-023 A tx_valid arriving during TX, GUARD or RX waits. It is accepted at the first IDLE tick after the RX slot completes, which is exactly one tick after RX exits.
REQ-024 The slot counter is 8 bits and never exceeds max(TX_TICKS, RX_TICKS)-1.

Reset
REQ-025 While reset=1 at a clock edge, the following are forced:
  - state=IDLE; tick counter and slot counter = 0;
  - enc_enable=0, dec_enable=0, rx_valid=0, tx_ready=0;
  - enc_data=0, rx_data=0, busy=0.
REQ-026 Reset during TX or RX aborts the slot immediately. A partially received byte is not captured and no rx_valid is produced.
REQ-027 After reset is released, the first tick occurs TICK_DIV cycles later.

Structure
REQ-028 The shared package freq_pkg holds:
  - the state enum type (IDLE, TX, GUARD, RX);
  - the 24-bit tick-width constant;
  - the 8-bit data-width constant.
REQ-029 The tick generator is one sub-module, freq_tick_gen, with inputs clk and reset, parameter TICK_DIV, and output tick. The FSM, slot counter and data registers stay in freq_link_sched.

Verification (TICK_DIV=4, TX_TICKS=2, RX_TICKS=3 unless noted)
REQ-030 Reset released, tx_valid=0 → first tick at cycle 4 → RX for 12 cycles with dec_enable=1 → at the end rx_valid pulses once with rx_data = dec_data sampled on the final tick → back to IDLE.
REQ-031 tx_valid=1, tx_data=8'hA5 from reset → tx_ready high for 1 cycle at the first tick → enc_data=8'hA5 and enc_enable=1 for 8 cycles → GUARD 4 cycles with both enables 0 → RX 12 cycles → rx_valid.
REQ-032 Second byte 8'h3C offered during RX → not accepted until the first IDLE tick after RX → enc_data stays 8'hA5 until that acceptance.
REQ-033 Reset asserted in the middle of RX → next cycle: state=IDLE, dec_enable=0, no rx_valid, rx_data unchanged at 0.
REQ-034 Continuous tx_valid for 4 bytes → strict alternation TX,GUARD,RX,IDLE; assertion that enc_enable and dec_enable are never both high; TX_TICKS=RX_TICKS=1 edge case also passes.

Source files
------------

// File: rtl/freq_pkg.sv
// Shared types and widths for the frequency-link slot scheduler.
package freq_pkg;

  localparam int TICK_W = 24;
  localparam int DATA_W = 8;
  localparam int SLOT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TX    = 2'd1,
    GUARD = 2'd2,
    RX    = 2'd3
  } slot_state_e;

endpackage

// File: rtl/freq_tick_gen.sv
// Slot tick generator: free-running divide-by-TICK_DIV counter, one-cycle tick on the last count.
module freq_tick_gen
  import freq_pkg::*;
#(
  parameter logic [TICK_W-1:0] TICK_DIV = 24'd10_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [TICK_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == TICK_DIV - TICK_W'(1));

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + TICK_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/freq_link_sched.sv
// Half-duplex slot scheduler: alternates TX, a one-tick GUARD and an RX listening slot,
// handing bytes to the frequency encoder and collecting bytes from the decoder.
module freq_link_sched
  import freq_pkg::*;
#(
  parameter logic [TICK_W-1:0] TICK_DIV = 24'd10_000_000,
  parameter logic [SLOT_W-1:0] TX_TICKS = 8'd8,
  parameter logic [SLOT_W-1:0] RX_TICKS = 8'd8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic [DATA_W-1:0] enc_data,
  output logic              enc_enable,
  input  logic [DATA_W-1:0] dec_data,
  output logic              dec_enable,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic [1:0]        slot_state,
  output logic              busy
);

  logic tick;

  freq_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  slot_state_e       state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [DATA_W-1:0] enc_data_q, enc_data_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              enc_en_q, enc_en_d;
  logic              dec_en_q, dec_en_d;

  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    enc_data_d = enc_data_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        // An idle slot with nothing to send is spent listening.
        tx_ready = tick;
        if (tick) begin
          slot_d = '0;
          if (tx_valid) begin
            enc_data_d = tx_data;
            state_d    = TX;
          end else begin
            state_d = RX;
          end
        end
      end
      TX: begin
        if (tick) begin
          if (slot_q == TX_TICKS - SLOT_W'(1)) begin
            state_d = GUARD;
            slot_d  = '0;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      GUARD: begin
        if (tick) begin
          state_d = RX;
          slot_d  = '0;
        end
      end
      RX: begin
        if (tick) begin
          if (slot_q == RX_TICKS - SLOT_W'(1)) begin
            rx_data_d  = dec_data;
            rx_valid_d = 1'b1;
            state_d    = IDLE;
            slot_d     = '0;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        slot_d  = '0;
      end
    endcase

    // Both enables decode the same next state, so they can never overlap.
    enc_en_d = (state_d == TX);
    dec_en_d = (state_d == RX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      slot_q     <= '0;
      enc_data_q <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      enc_en_q   <= 1'b0;
      dec_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      enc_data_q <= enc_data_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      enc_en_q   <= enc_en_d;
      dec_en_q   <= dec_en_d;
    end
  end

  assign enc_data   = enc_data_q;
  assign enc_enable = enc_en_q;
  assign dec_enable = dec_en_q;
  assign rx_valid   = rx_valid_q;
  assign rx_data    = rx_data_q;
  assign slot_state = state_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_freq_link_sched.sv
// Directed bench: dut A uses TICK_DIV=4/TX=2/RX=3, dut B uses TICK_DIV=4/TX=1/RX=1.
module tb_freq_link_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [7:0] dec_data = 8'h00;

  logic       a_tx_ready, a_enc_en, a_dec_en, a_rx_valid, a_busy;
  logic [7:0] a_enc_data, a_rx_data;
  logic [1:0] a_state;
  logic       b_tx_ready, b_enc_en, b_dec_en, b_rx_valid, b_busy;
  logic [7:0] b_enc_data, b_rx_data;
  logic [1:0] b_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  freq_link_sched #(.TICK_DIV(24'd4), .TX_TICKS(8'd2), .RX_TICKS(8'd3)) u_dut_a (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(a_tx_ready), .enc_data(a_enc_data), .enc_enable(a_enc_en),
    .dec_data(dec_data), .dec_enable(a_dec_en), .rx_valid(a_rx_valid),
    .rx_data(a_rx_data), .slot_state(a_state), .busy(a_busy)
  );

  freq_link_sched #(.TICK_DIV(24'd4), .TX_TICKS(8'd1), .RX_TICKS(8'd1)) u_dut_b (
    .clk(clk), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(b_tx_ready), .enc_data(b_enc_data), .enc_enable(b_enc_en),
    .dec_data(dec_data), .dec_enable(b_dec_en), .rx_valid(b_rx_valid),
    .rx_data(b_rx_data), .slot_state(b_state), .busy(b_busy)
  );

  // {state, tx_ready, enc_enable, dec_enable, busy, rx_valid, enc_data, rx_data}
  logic [22:0] a_vec, b_vec;
  assign a_vec = {a_state, a_tx_ready, a_enc_en, a_dec_en, a_busy, a_rx_valid, a_enc_data, a_rx_data};
  assign b_vec = {b_state, b_tx_ready, b_enc_en, b_dec_en, b_busy, b_rx_valid, b_enc_data, b_rx_data};

  // Returns at a falling edge where cycle 0 after reset begins (tick counter = 0).
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    repeat (3) @(negedge clk);
    checks++;
    if (a_vec !== 23'h0) begin
      failures++;
      $display("FAIL reset_a got=%h want=%h", a_vec, 23'h0);
    end
    checks++;
    if (b_vec !== 23'h0) begin
      failures++;
      $display("FAIL reset_b got=%h want=%h", b_vec, 23'h0);
    end
    $display("reset: a=%h b=%h", a_vec, b_vec);
  endtask

  task automatic test_idle_rx();
    logic [1:0]  es;
    logic [22:0] exp_v;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    do_reset();
    for (int k = 0; k <= 17; k++) begin
      es    = (k >= 4 && k <= 15) ? 2'd3 : 2'd0;
      exp_v = {es, (k == 3), (es == 2'd1), (es == 2'd3), (es != 2'd0), (k == 16),
               8'h00, (k >= 16) ? 8'h4F : 8'h00};
      checks++;
      if (a_vec !== exp_v) begin
        failures++;
        $display("FAIL idle_rx k=%0d got=%h want=%h", k, a_vec, exp_v);
      end
      $display("idle_rx k=%0d vec=%h", k, a_vec);
      dec_data = 8'(8'h40 + k);
      @(negedge clk);
    end
  endtask

  task automatic test_tx_then_wait();
    logic [1:0]  es;
    logic [7:0]  eed;
    logic [22:0] exp_v;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    do_reset();
    for (int k = 0; k <= 32; k++) begin
      es  = (k < 4) ? 2'd0 : (k < 12) ? 2'd1 : (k < 16) ? 2'd2 : (k < 28) ? 2'd3 :
            (k < 32) ? 2'd0 : 2'd1;
      eed = (k < 4) ? 8'h00 : (k < 32) ? 8'hA5 : 8'h3C;
      exp_v = {es, (k == 3 || k == 31), (es == 2'd1), (es == 2'd3), (es != 2'd0), (k == 28),
               eed, (k >= 28) ? 8'h5B : 8'h00};
      checks++;
      if (a_vec !== exp_v) begin
        failures++;
        $display("FAIL tx_then_wait k=%0d got=%h want=%h", k, a_vec, exp_v);
      end
      $display("tx_then_wait k=%0d vec=%h", k, a_vec);
      tx_valid = (k <= 3) || (k >= 20);
      tx_data  = (k <= 3) ? 8'hA5 : (k < 20) ? 8'hFF : 8'h3C;
      dec_data = 8'(8'h40 + k);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid_rx();
    logic [1:0]  es;
    logic [22:0] exp_v;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    do_reset();
    for (int k = 0; k < 10; k++) begin
      dec_data = 8'(8'h40 + k);
      @(negedge clk);
    end
    checks++;
    if (a_state !== 2'd3 || a_dec_en !== 1'b1) begin
      failures++;
      $display("FAIL mid_rx_pre state=%0d dec_en=%0b want 3/1", a_state, a_dec_en);
    end
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (a_vec !== 23'h0) begin
        failures++;
        $display("FAIL mid_rx_reset k=%0d got=%h want=%h", k, a_vec, 23'h0);
      end
      $display("mid_rx_reset k=%0d vec=%h", k, a_vec);
    end
    reset = 1'b0;
    for (int k = 0; k <= 4; k++) begin
      es    = (k == 4) ? 2'd3 : 2'd0;
      exp_v = {es, (k == 3), 1'b0, (es == 2'd3), (es != 2'd0), 1'b0, 8'h00, 8'h00};
      checks++;
      if (a_vec !== exp_v) begin
        failures++;
        $display("FAIL post_reset_tick k=%0d got=%h want=%h", k, a_vec, exp_v);
      end
      $display("post_reset_tick k=%0d vec=%h", k, a_vec);
      @(negedge clk);
    end
  endtask

  // Four bytes with tx_valid held high; which=0 checks dut A, which=1 checks dut B.
  task automatic test_back_to_back(input int which);
    logic [7:0]  bytes [4];
    int          per, txc, rxc, o, nn;
    logic [1:0]  es;
    logic [7:0]  eed, erd;
    logic [22:0] exp_v, obs;
    bytes[0] = 8'hA1; bytes[1] = 8'hB2; bytes[2] = 8'hC3; bytes[3] = 8'hD4;
    txc = (which == 0) ? 8 : 4;
    rxc = (which == 0) ? 12 : 4;
    per = txc + 4 + rxc + 4;
    erd = 8'h00;
    tx_valid = 1'b1;
    tx_data  = bytes[0];
    do_reset();
    for (int k = 0; k <= 4 * per + 3; k++) begin
      o   = (k >= 4) ? (k - 4) % per : 0;
      if (k < 4)                  es = 2'd0;
      else if (o < txc)           es = 2'd1;
      else if (o < txc + 4)       es = 2'd2;
      else if (o < txc + 4 + rxc) es = 2'd3;
      else                        es = 2'd0;
      eed   = (k < 4) ? 8'h00 : bytes[(k - 4) / per];
      exp_v = {es, (k == 3) || (k >= 4 && o == per - 1), (es == 2'd1), (es == 2'd3),
               (es != 2'd0), (k >= 4 && o == txc + 4 + rxc), eed, erd};
      obs   = (which == 0) ? a_vec : b_vec;
      checks++;
      if (obs !== exp_v) begin
        failures++;
        $display("FAIL back_to_back%0d k=%0d got=%h want=%h", which, k, obs, exp_v);
      end
      checks++;
      if ((a_enc_en && a_dec_en) || (b_enc_en && b_dec_en)) begin
        failures++;
        $display("FAIL enable_overlap k=%0d a=%0b%0b b=%0b%0b want no overlap", k,
                 a_enc_en, a_dec_en, b_enc_en, b_dec_en);
      end
      $display("back_to_back%0d k=%0d vec=%h", which, k, obs);
      if (k >= 4 && o == txc + 4 + rxc - 1) erd = 8'(8'h40 + k);
      nn       = (k < 4) ? 0 : (k - 4) / per + 1;
      tx_valid = (nn < 4);
      tx_data  = (nn < 4) ? bytes[nn] : 8'h00;
      dec_data = 8'(8'h40 + k);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_idle_rx();
    test_tx_then_wait();
    test_reset_mid_rx();
    test_back_to_back(0);
    test_back_to_back(1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
